// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller bundle: hazard inputs, pipeline controls, perf counters
//   master: pipeline side, drives register/branch/imem status, receives controls
//   slave : hazard_ctrl, consumes status, drives controls, state and counters
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             mem_branch_taken;
    logic             imem_ready;
    logic             cnt_clear;
    logic             pc_write;
    logic             ifid_write_n;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
               mem_branch_taken, imem_ready, cnt_clear,
        input  pc_write, ifid_write_n, ifid_flush, idex_bubble, exmem_flush,
               state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
               mem_branch_taken, imem_ready, cnt_clear,
        output pc_write, ifid_write_n, ifid_flush, idex_bubble, exmem_flush,
               state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard/stall controller with saturating event counters
//   clk   : pipeline clock
//   reset : synchronous, active-high
//   bus   : hazard_ctrl_if.slave (hazard status in; PC/IF-ID/ID-EX/EX-MEM controls,
//           FSM state and stall/flush counters out)
module hazard_ctrl #(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 32
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        IWAIT = 2'd2
    } state_t;

    // The detection cycle is stall cycle 1 and the STALL exit cycle is the last,
    // so the down-counter starts at LOAD_STALL-2.
    localparam bit       MULTI_STALL = (LOAD_STALL > 1);
    localparam logic [1:0] STALL_INIT = MULTI_STALL ? 2'(LOAD_STALL - 2) : 2'd0;

    state_t           state_q, state_d;
    logic [1:0]       dcnt_q, dcnt_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             luh;
    logic             pc_write, ifid_write_n, ifid_flush, idex_bubble, exmem_flush;

    assign luh = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                 ((bus.ex_rd == bus.id_rs1) ||
                  (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));

    always_comb begin
        pc_write     = 1'b1;
        ifid_write_n = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_flush  = 1'b0;
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        if (bus.mem_branch_taken) begin
            // Redirect wins everywhere; the younger instructions in IF/ID, ID/EX and EX/MEM are squashed.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            state_d     = RUN;
            dcnt_d      = 2'd0;
        end else begin
            case (state_q)
                // IWAIT with imem_ready behaves exactly like RUN, so both share this rule.
                RUN, IWAIT: begin
                    if (!bus.imem_ready) begin
                        pc_write   = 1'b0;
                        ifid_flush = 1'b1;
                        state_d    = IWAIT;
                    end else if (luh) begin
                        pc_write     = 1'b0;
                        ifid_write_n = 1'b1;
                        idex_bubble  = 1'b1;
                        if (MULTI_STALL) begin
                            state_d = STALL;
                            dcnt_d  = STALL_INIT;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                STALL: begin
                    pc_write     = 1'b0;
                    ifid_write_n = 1'b1;
                    idex_bubble  = 1'b1;
                    if (dcnt_q == 2'd0) begin
                        state_d = RUN;
                    end else begin
                        dcnt_d = dcnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    dcnt_d  = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            dcnt_q  <= 2'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            if (bus.cnt_clear) begin
                stall_q <= '0;
            end else if (!pc_write && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (bus.cnt_clear) begin
                flush_q <= '0;
            end else if (bus.mem_branch_taken && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.ifid_write_n = ifid_write_n;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.exmem_flush  = exmem_flush;
    assign bus.state        = state_q;
    assign bus.stall_cnt    = stall_q;
    assign bus.flush_cnt    = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl (LOAD_STALL 1/3, CNT_W 32/4)
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(32)) b1 ();
    hazard_ctrl_if #(.CNT_W(32)) b3 ();
    hazard_ctrl_if #(.CNT_W(4))  b4 ();

    hazard_ctrl #(.LOAD_STALL(1), .CNT_W(32)) u1 (.clk(clk), .reset(reset), .bus(b1));
    hazard_ctrl #(.LOAD_STALL(3), .CNT_W(32)) u3 (.clk(clk), .reset(reset), .bus(b3));
    hazard_ctrl #(.LOAD_STALL(3), .CNT_W(4))  u4 (.clk(clk), .reset(reset), .bus(b4));

    // {pc_write, ifid_write_n, ifid_flush, idex_bubble, exmem_flush}
    localparam logic [4:0] RUNSET = 5'b10000;
    localparam logic [4:0] LSTALL = 5'b01010;
    localparam logic [4:0] IWSET  = 5'b00100;
    localparam logic [4:0] BRSET  = 5'b10111;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] ctl(input int n);
        case (n)
            1:       return {b1.pc_write, b1.ifid_write_n, b1.ifid_flush, b1.idex_bubble, b1.exmem_flush};
            3:       return {b3.pc_write, b3.ifid_write_n, b3.ifid_flush, b3.idex_bubble, b3.exmem_flush};
            default: return {b4.pc_write, b4.ifid_write_n, b4.ifid_flush, b4.idex_bubble, b4.exmem_flush};
        endcase
    endfunction

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses2,
                          input logic [4:0] rd, input logic memrd, input logic br,
                          input logic rdy, input logic clr);
        b1.id_rs1 = rs1; b1.id_rs2 = rs2; b1.id_uses_rs2 = uses2; b1.ex_rd = rd;
        b1.ex_mem_read = memrd; b1.mem_branch_taken = br; b1.imem_ready = rdy; b1.cnt_clear = clr;
        b3.id_rs1 = rs1; b3.id_rs2 = rs2; b3.id_uses_rs2 = uses2; b3.ex_rd = rd;
        b3.ex_mem_read = memrd; b3.mem_branch_taken = br; b3.imem_ready = rdy; b3.cnt_clear = clr;
        b4.id_rs1 = rs1; b4.id_rs2 = rs2; b4.id_uses_rs2 = uses2; b4.ex_rd = rd;
        b4.ex_mem_read = memrd; b4.mem_branch_taken = br; b4.imem_ready = rdy; b4.cnt_clear = clr;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        // Reset behaviour
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ctl", ctl(3), RUNSET);
        check("rst_state", b3.state, 0);
        reset = 1'b0;
        repeat (3) next_cycle();
        #1;
        check("idle_ctl", ctl(3), RUNSET);
        check("idle_state", b3.state, 0);
        check("idle_stall_cnt", b3.stall_cnt, 0);
        check("idle_flush_cnt", b3.flush_cnt, 0);

        // LOAD_STALL=1, one-cycle load-use on rs1
        next_cycle();
        set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("ls1_stall_ctl", ctl(1), LSTALL);
        next_cycle();
        idle();
        #1;
        check("ls1_after_ctl", ctl(1), RUNSET);
        check("ls1_state", b1.state, 0);
        check("ls1_stall_cnt", b1.stall_cnt, 1);

        // LOAD_STALL=3
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("ls3_rd0_ctl", ctl(3), RUNSET);
        next_cycle();
        set_in(5'd0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("ls3_c1_ctl", ctl(3), LSTALL);
        check("ls3_c1_state", b3.state, 0);
        next_cycle();
        idle();
        #1;
        check("ls3_c2_ctl", ctl(3), LSTALL);
        check("ls3_c2_state", b3.state, 1);
        next_cycle();
        #1;
        check("ls3_c3_ctl", ctl(3), LSTALL);
        check("ls3_c3_state", b3.state, 1);
        next_cycle();
        #1;
        check("ls3_end_ctl", ctl(3), RUNSET);
        check("ls3_end_state", b3.state, 0);
        check("ls3_stall_cnt", b3.stall_cnt, 3);
        set_in(5'd0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("ls3_nouse2_ctl", ctl(3), RUNSET);

        // Instruction memory wait, 4 cycles
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("iw_c1_ctl", ctl(3), IWSET);
        check("iw_c1_state", b3.state, 0);
        for (int i = 2; i <= 4; i++) begin
            next_cycle();
            #1;
            check($sformatf("iw_c%0d_ctl", i), ctl(3), IWSET);
            check($sformatf("iw_c%0d_state", i), b3.state, 2);
        end
        next_cycle();
        idle();
        #1;
        check("iw_ready_ctl", ctl(3), RUNSET);
        check("iw_ready_state", b3.state, 2);
        next_cycle();
        #1;
        check("iw_exit_state", b3.state, 0);
        check("iw_stall_cnt", b3.stall_cnt, 4);

        // Branch in the 2nd cycle of a LOAD_STALL=3 stall
        do_reset();
        set_in(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("br_c1_ctl", ctl(3), LSTALL);
        next_cycle();
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        check("br_c2_state", b3.state, 1);
        check("br_c2_ctl", ctl(3), BRSET);
        next_cycle();
        idle();
        #1;
        check("br_after_state", b3.state, 0);
        check("br_after_ctl", ctl(3), RUNSET);
        check("br_flush_cnt", b3.flush_cnt, 1);
        check("br_stall_cnt", b3.stall_cnt, 1);

        // Branch during IWAIT aborts the wait
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("briw_state", b3.state, 2);
        check("briw_ctl", ctl(3), BRSET);
        next_cycle();
        idle();
        #1;
        check("briw_after_state", b3.state, 0);

        // Saturation on the CNT_W=4 build
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (17) next_cycle();
        #1;
        check("sat_stall_cnt", b4.stall_cnt, 15);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (17) next_cycle();
        #1;
        check("sat_flush_cnt", b4.flush_cnt, 15);
        check("sat_stall_hold", b4.stall_cnt, 15);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        next_cycle();
        idle();
        #1;
        check("clr_stall_cnt", b4.stall_cnt, 0);
        check("clr_flush_cnt", b4.flush_cnt, 0);
        next_cycle();
        #1;
        check("clr_idle_state", b4.state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It sequences PC update, IF/ID hold and flush, ID/EX bubble insertion and EX/MEM flush for three hazard types: taken branches resolved in MEM, instruction-memory wait and load-use. It also keeps saturating stall and flush event counters for performance debug. It sits beside the IF/ID register and drives that register's flush and active-low write-enable inputs directly.

## Interface
- LOAD_STALL, 1: load-use stall length in cycles; legal range 1-3 (1 = MEM->EX forwarding present).
- CNT_W, 32: width of the performance counters.
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs2  in  1  the ID instruction reads rs2.
- ex_rd  in  5  rd of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- mem_branch_taken  in  1  the branch in MEM is taken; the PC mux selects the target.
- imem_ready  in  1  instruction memory returns a valid word this cycle.
- cnt_clear  in  1  synchronous clear of both counters.
- pc_write  out  1  1 = PC loads its next value; 0 = PC holds.
- ifid_write_n  out  1  0 = IF/ID loads; 1 = IF/ID holds.
- ifid_flush  out  1  IF/ID loads zeros (bubble).
- idex_bubble  out  1  ID/EX loads a NOP.
- exmem_flush  out  1  EX/MEM loads a NOP.
- state  out  2  current FSM state: RUN=0, STALL=1, IWAIT=2.
- stall_cnt  out  CNT_W  count of cycles with pc_write=0.
- flush_cnt  out  CNT_W  count of taken-branch flush events.

## Operation
- Load-use hazard is `luh = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)))`.
- Control outputs are combinational from state and inputs. State, the down-counter and the performance counters are registered.
- Default output set ("run set"): pc_write=1, ifid_write_n=0, all flushes 0.
- Priority in every state: mem_branch_taken first, then the state-specific rule.
- Branch rule, any state: pc_write=1, ifid_write_n=0, ifid_flush=1, idex_bubble=1, exmem_flush=1. Next state is RUN, the down-counter clears, and flush_cnt increments.
- RUN state:
  - If !imem_ready: pc_write=0, ifid_flush=1. Next state is IWAIT.
  - Else if luh: pc_write=0, ifid_write_n=1, idex_bubble=1.
    - If LOAD_STALL>1: next state is STALL with down-counter = LOAD_STALL-2.
    - Otherwise stay in RUN.
  - Else: run set.
- STALL state:
  - Outputs as in the RUN luh case. luh and imem_ready are ignored.
  - If down-counter is 0, next state is RUN; otherwise decrement.
- IWAIT state:
  - While !imem_ready: pc_write=0, ifid_flush=1.
  - When imem_ready is high: apply the RUN rules this cycle (run set or luh stall) and leave IWAIT accordingly.
- Counters:
  - stall_cnt increments in every cycle where pc_write=0.
  - Both counters saturate at all-ones.
  - cnt_clear has priority over increment; a clear and an event in the same cycle leave the counter at 0.

## Timing
- Reset values: state=RUN, down-counter=0, stall_cnt=0, flush_cnt=0.
- While reset is high, outputs show the RUN run set (with inputs idle). Reset mid-STALL or mid-IWAIT returns to RUN on the next edge.
- Zero-latency control: hazard detection and output response happen in the same cycle as the inputs. Registers act on the next clk edge.
- Load-use stall lasts exactly LOAD_STALL cycles, counted from the detection cycle.
- A taken branch during STALL or IWAIT aborts the stall in that cycle. The imem side aborts any pending fetch on pc_write with a redirect.
- ifid_flush and ifid_write_n=1 are never asserted together.
- No combinational path exists from counters to control outputs.

## Test plan
- Reset, then idle inputs with imem_ready=1: state=0, pc_write=1, ifid_write_n=0, all flushes 0, counters remain 0.
- LOAD_STALL=1, ex_mem_read=1, ex_rd=5, id_rs1=5, for one cycle: one cycle of pc_write=0, ifid_write_n=1, idex_bubble=1, then the run set; stall_cnt=1.
- Repeat with LOAD_STALL=3 and ex_rd=0:
  - ex_rd=0 gives no stall.
  - ex_rd=7 with id_rs2=7 and id_uses_rs2=1 gives 3 stall cycles, with state going 0 -> 1 -> 1 -> 0; stall_cnt=3.
  - The same case with id_uses_rs2=0 gives no stall.
- imem_ready=0 for 4 cycles: pc_write=0 and ifid_flush=1 for 4 cycles with state=2, then the run set; stall_cnt=4.
- mem_branch_taken in the 2nd cycle of a LOAD_STALL=3 stall: that cycle shows all three flushes and pc_write=1, state then returns to 0, flush_cnt=1, stall_cnt=1.
- Preload both counters to saturation (CNT_W=4 build), then trigger events: the counters hold at 15. cnt_clear together with an event gives 0.
